// File: rtl/mem_access_unit_if.sv
// Word-addressed data-memory bus between the memory stage and external data memory.
// The master modport is the requester; the slave modport is the memory.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory stage after the ALU: the load/store req/ack handshake stalls the PC until the access
// completes or times out. Non-memory results pass straight through to writeback.
module mem_access_unit #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               reg_write,
  input  logic [31:0]        data_ULA,
  input  logic [31:0]        data_tgt,
  mem_access_unit_if.master  mem,
  output logic               stall,
  output logic               wb_valid,
  output logic [31:0]        data_wb,
  output logic               mem_err
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic mem_op_c;
  logic oor_c;
  logic timeout_c;

  assign mem_op_c  = mem_read | mem_write;
  assign oor_c     = (data_ULA >> ADDR_W) != 32'd0;
  assign timeout_c = cnt_q == CNT_W'(TIMEOUT - 1);

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; DONE always returns to IDLE so held op inputs never re-trigger
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (mem_op_c) state_nxt = oor_c ? DONE : BUSY;
      BUSY:    if (mem.mem_ack || timeout_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall and writeback outputs; forced low while reset is held
  always_comb begin
    stall    = 1'b0;
    wb_valid = 1'b0;
    data_wb  = 32'd0;
    if (reset) begin
      unique case (state)
        IDLE: begin
          if (mem_op_c) begin
            stall = 1'b1;
          end else begin
            wb_valid = reg_write;
            data_wb  = data_ULA;
          end
        end
        BUSY: stall = 1'b1;
        DONE: begin
          if (we_q) begin
            data_wb = data_ULA;
          end else begin
            wb_valid = reg_write;
            data_wb  = rdata_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Request latches, timeout counter, read-data latch and sticky error
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      mem_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_op_c) begin
            we_q <= mem_write;
            if (oor_c) begin
              mem_err <= 1'b1;
              rdata_q <= 32'd0;
            end else begin
              addr_q  <= data_ULA[ADDR_W-1:0];
              wdata_q <= data_tgt;
              req_q   <= 1'b1;
              cnt_q   <= '0;
            end
          end
        end
        BUSY: begin
          if (mem.mem_ack) begin
            req_q <= 1'b0;
            if (!we_q) rdata_q <= mem.mem_rdata;
          end else if (timeout_c) begin
            req_q   <= 1'b0;
            mem_err <= 1'b1;
            rdata_q <= 32'd0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: pass-through, load/store handshakes, range error,
// timeout, and reset in the middle of an access.
module tb_mem_access_unit;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned TIMEOUT = 16;

  logic        clock;
  logic        reset;
  logic        mem_read, mem_write, reg_write;
  logic [31:0] data_ULA, data_tgt;
  logic        stall, wb_valid, mem_err;
  logic [31:0] data_wb;

  int tests;
  int fails;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock    (clock),
    .reset    (reset),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .reg_write(reg_write),
    .data_ULA (data_ULA),
    .data_tgt (data_tgt),
    .mem      (bus),
    .stall    (stall),
    .wb_valid (wb_valid),
    .data_wb  (data_wb),
    .mem_err  (mem_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Called at posedge+1 with an op applied; plays memory, acking in request cycle ack_at (0 = never).
  task automatic run_op(input int ack_at, input logic [31:0] rdata,
                        output int stall_n, output int req_n, output int total,
                        output logic [31:0] wb, output logic wbv,
                        output logic [ADDR_W-1:0] addr0, output logic we0,
                        output logic [31:0] wdata0, output logic held, output logic done);
    stall_n = 0; req_n = 0; total = 0; wb = 32'd0; wbv = 1'b0;
    addr0 = '0; we0 = 1'b0; wdata0 = 32'd0; held = 1'b1; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      bus.mem_rdata = rdata;
      bus.mem_ack   = (ack_at > 0 && bus.mem_req && (req_n + 1 == ack_at)) ? 1'b1 : 1'b0;
      @(negedge clock);
      if (bus.mem_req) begin
        if (req_n == 0) begin
          addr0 = bus.mem_addr; we0 = bus.mem_we; wdata0 = bus.mem_wdata;
        end else if (bus.mem_addr !== addr0 || bus.mem_we !== we0 || bus.mem_wdata !== wdata0) begin
          held = 1'b0;
        end
        req_n++;
      end
      if (stall) begin
        stall_n++;
      end else if (stall_n > 0) begin
        done = 1'b1; wb = data_wb; wbv = wb_valid; total = i + 1;
        mem_read = 1'b0; mem_write = 1'b0;
      end
      @(posedge clock); #1;
      bus.mem_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; reg_write = 1'b1; data_ULA = 32'h0000_ABCD;
    repeat (2) @(posedge clock);
    @(negedge clock);
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", bus.mem_req); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", stall); end
    tests++; if (wb_valid !== 1'b0 || data_wb !== 32'd0) begin fails++; $display("FAIL reset_wb got %b/%h exp 0/0", wb_valid, data_wb); end
    tests++; if (mem_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", mem_err); end
    tests++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== 32'd0) begin
      fails++; $display("FAIL reset_bus got we=%b addr=%0d wdata=%h exp 0", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_passthrough();
    int req_seen;
    req_seen = 0;
    reg_write = 1'b1; data_ULA = 32'h0000_002A;
    #1;
    tests++; if (stall !== 1'b0 || wb_valid !== 1'b1 || data_wb !== 32'd42) begin
      fails++; $display("FAIL pass_same_cycle got stall=%b wbv=%b wb=%h exp 0/1/2a", stall, wb_valid, data_wb); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (bus.mem_req !== 1'b0) req_seen++;
      @(posedge clock); #1;
    end
    reg_write = 1'b0; data_ULA = 32'h0000_0077; #1;
    tests++; if (wb_valid !== 1'b0 || data_wb !== 32'h77) begin
      fails++; $display("FAIL pass_noreg got wbv=%b wb=%h exp 0/77", wb_valid, data_wb); end
    tests++; if (req_seen !== 0) begin fails++; $display("FAIL pass_req got %0d req cycles exp 0", req_seen); end
  endtask

  task automatic test_load();
    int sn, rn, tot; logic [31:0] wb, wd; logic wbv, we0, held, done; logic [ADDR_W-1:0] a0;
    mem_read = 1'b1; reg_write = 1'b1; data_ULA = 32'd5; data_tgt = 32'h5555_AAAA;
    #1;
    tests++; if (stall !== 1'b1 || bus.mem_req !== 1'b0) begin
      fails++; $display("FAIL load_idle got stall=%b req=%b exp 1/0", stall, bus.mem_req); end
    run_op(3, 32'hDEAD_BEEF, sn, rn, tot, wb, wbv, a0, we0, wd, held, done);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL load_done got %b exp 1", done); end
    tests++; if (sn !== 4 || rn !== 3 || tot !== 5) begin
      fails++; $display("FAIL load_timing got stall=%0d req=%0d total=%0d exp 4/3/5", sn, rn, tot); end
    tests++; if (a0 !== 10'd5 || we0 !== 1'b0 || held !== 1'b1) begin
      fails++; $display("FAIL load_bus got addr=%0d we=%b held=%b exp 5/0/1", a0, we0, held); end
    tests++; if (wb !== 32'hDEAD_BEEF || wbv !== 1'b1) begin
      fails++; $display("FAIL load_wb got %h/%b exp deadbeef/1", wb, wbv); end
  endtask

  task automatic test_store();
    int sn, rn, tot; logic [31:0] wb, wd; logic wbv, we0, held, done; logic [ADDR_W-1:0] a0;
    mem_write = 1'b1; reg_write = 1'b1; data_ULA = 32'd1023; data_tgt = 32'h1234_5678;
    run_op(1, 32'h0BAD_0BAD, sn, rn, tot, wb, wbv, a0, we0, wd, held, done);
    tests++; if (done !== 1'b1 || sn !== 2 || rn !== 1 || tot !== 3) begin
      fails++; $display("FAIL store_timing got done=%b stall=%0d req=%0d total=%0d exp 1/2/1/3", done, sn, rn, tot); end
    tests++; if (a0 !== 10'd1023 || we0 !== 1'b1 || wd !== 32'h1234_5678) begin
      fails++; $display("FAIL store_bus got addr=%0d we=%b wdata=%h exp 1023/1/12345678", a0, we0, wd); end
    tests++; if (wbv !== 1'b0 || wb !== 32'd1023) begin
      fails++; $display("FAIL store_wb got %b/%h exp 0/3ff", wbv, wb); end
    tests++; if (mem_err !== 1'b0) begin fails++; $display("FAIL store_err got %b exp 0", mem_err); end
  endtask

  task automatic test_out_of_range();
    int sn, rn, tot; logic [31:0] wb, wd; logic wbv, we0, held, done; logic [ADDR_W-1:0] a0;
    mem_read = 1'b1; reg_write = 1'b1; data_ULA = 32'd1024;
    run_op(1, 32'hFFFF_FFFF, sn, rn, tot, wb, wbv, a0, we0, wd, held, done);
    tests++; if (done !== 1'b1 || rn !== 0 || tot !== 2) begin
      fails++; $display("FAIL oor_timing got done=%b req=%0d total=%0d exp 1/0/2", done, rn, tot); end
    tests++; if (wb !== 32'd0 || wbv !== 1'b1) begin fails++; $display("FAIL oor_wb got %h/%b exp 0/1", wb, wbv); end
    tests++; if (mem_err !== 1'b1) begin fails++; $display("FAIL oor_err got %b exp 1", mem_err); end
  endtask

  task automatic test_timeout();
    int sn, rn, tot; logic [31:0] wb, wd; logic wbv, we0, held, done; logic [ADDR_W-1:0] a0;
    mem_read = 1'b1; reg_write = 1'b1; data_ULA = 32'd9;
    run_op(0, 32'h1111_2222, sn, rn, tot, wb, wbv, a0, we0, wd, held, done);
    tests++; if (done !== 1'b1 || rn !== 16 || sn !== 17 || tot !== 18) begin
      fails++; $display("FAIL timeout_timing got done=%b req=%0d stall=%0d total=%0d exp 1/16/17/18", done, rn, sn, tot); end
    tests++; if (wb !== 32'd0 || mem_err !== 1'b1) begin
      fails++; $display("FAIL timeout_result got wb=%h err=%b exp 0/1", wb, mem_err); end
    data_ULA = 32'h0000_0033;
    @(negedge clock);
    tests++; if (stall !== 1'b0 || bus.mem_req !== 1'b0 || wb_valid !== 1'b1 || data_wb !== 32'h33) begin
      fails++; $display("FAIL timeout_idle got stall=%b req=%b wbv=%b wb=%h exp 0/0/1/33", stall, bus.mem_req, wb_valid, data_wb); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_busy();
    int sn, rn, tot; logic [31:0] wb, wd; logic wbv, we0, held, done; logic [ADDR_W-1:0] a0;
    mem_read = 1'b1; reg_write = 1'b1; data_ULA = 32'd3;
    @(posedge clock); #1;
    @(posedge clock); #1;
    tests++; if (bus.mem_req !== 1'b1 || stall !== 1'b1) begin
      fails++; $display("FAIL midreset_busy got req=%b stall=%b exp 1/1", bus.mem_req, stall); end
    #2 reset = 1'b0;
    #1;
    tests++; if (bus.mem_req !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL midreset_drop got req=%b stall=%b exp 0/0", bus.mem_req, stall); end
    mem_read = 1'b0;
    @(negedge clock); reset = 1'b1;
    tests++; if (mem_err !== 1'b0) begin fails++; $display("FAIL midreset_err got %b exp 0", mem_err); end
    @(posedge clock); #1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clock);
    tests++; if (bus.mem_req !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL stray_ack got req=%b stall=%b exp 0/0", bus.mem_req, stall); end
    @(posedge clock); #1;
    bus.mem_ack = 1'b0;
    mem_read = 1'b1; reg_write = 1'b1; data_ULA = 32'd7;
    run_op(2, 32'hCAFE_F00D, sn, rn, tot, wb, wbv, a0, we0, wd, held, done);
    tests++; if (done !== 1'b1 || sn !== 3 || rn !== 2 || a0 !== 10'd7) begin
      fails++; $display("FAIL post_reset_timing got done=%b stall=%0d req=%0d addr=%0d exp 1/3/2/7", done, sn, rn, a0); end
    tests++; if (wb !== 32'hCAFE_F00D || wbv !== 1'b1 || mem_err !== 1'b0) begin
      fails++; $display("FAIL post_reset_wb got %h/%b err=%b exp cafef00d/1/0", wb, wbv, mem_err); end
  endtask

  initial begin
    tests = 0; fails = 0;
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
    data_ULA = 32'd0; data_tgt = 32'd0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
    test_reset();
    test_passthrough();
    test_load();
    test_store();
    test_out_of_range();
    test_timeout();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
